fetch_stage: RTL

- Parametrised instruction-fetch front end for the pipelined core: PC register, boot and interrupt vector loading, IF/ID pipeline register, stall/flush/redirect handling and interrupt injection.
- Drives the instruction-memory port A address and presents decoded-stage inputs to the control unit and register file.

---
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory port A between the fetch stage (master) and the memory (slave).
// The read is combinational: imem_rdata is valid in the same cycle as imem_addr.
interface fetch_stage_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, boot/interrupt vector loads, IF/ID register, stall/flush/redirect.
// Define FETCH_INTR_EDGE_EN for rising-edge interrupt requests; the default is level-sensitive.
module fetch_stage #(
    parameter int                   ADDR_W       = 8,
    parameter int                   INSTR_W      = 8,
    parameter logic [ADDR_W-1:0]    RST_VEC_ADDR = '0,
    parameter logic [ADDR_W-1:0]    INT_VEC_ADDR = ADDR_W'(1),
    parameter logic [INSTR_W-1:0]   INT_INSTR    = INSTR_W'(8'hB8),
    parameter logic [INSTR_W-1:0]   NOP_INSTR    = '0
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                pc_write_en,
    input  logic                if_id_write_en,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    input  logic                intr,
    input  logic                reti,
    output logic                intr_ack,
    output logic [ADDR_W-1:0]   saved_pc,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc_plus1,
    output logic                if_id_valid
);

    typedef enum logic [1:0] {BOOT, RUN, INT_VEC} state_t;

    state_t             state;
    logic               in_isr;
    logic               pending;
    logic               pending_next;
    logic               take;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [ADDR_W-1:0]  pc_plus1;
    logic [ADDR_W-1:0]  vec_pc;

    assign pc_plus1 = pc + ADDR_W'(1);
    assign vec_pc   = imem.imem_rdata[ADDR_W-1:0];

    // NOTE: give every always_comb output a default before any branch so no latch is inferred.
    always_comb begin
        fetch_addr = pc;
        case (state)
            BOOT:    fetch_addr = RST_VEC_ADDR;
            INT_VEC: fetch_addr = INT_VEC_ADDR;
            default: fetch_addr = pc;
        endcase
    end

    assign imem.imem_addr = fetch_addr;

    // Take only on a clean RUN cycle; in_isr is the pre-edge value, so a coincident reti cannot enable it.
    assign take = (state == RUN) && !redirect_valid && pending && !in_isr &&
                  pc_write_en && if_id_write_en && !flush;

`ifdef FETCH_INTR_EDGE_EN
    logic intr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) intr_d <= 1'b0;
        else     intr_d <= intr;
    end

    assign pending_next = (pending && !take) || (intr && !intr_d);
`else
    assign pending_next = take ? 1'b0 : intr;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BOOT;
            pc             <= '0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
            saved_pc       <= '0;
            intr_ack       <= 1'b0;
            in_isr         <= 1'b0;
            pending        <= 1'b0;
        end else begin
            intr_ack <= 1'b0;
            pending  <= pending_next;
            if (reti) in_isr <= 1'b0;

            case (state)
                BOOT, INT_VEC: begin
                    pc          <= vec_pc;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    state       <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc          <= redirect_addr;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else if (take) begin
                        // The injected instruction carries the interrupted PC as its return address.
                        if_id_instr    <= INT_INSTR;
                        if_id_valid    <= 1'b1;
                        if_id_pc_plus1 <= pc;
                        saved_pc       <= pc;
                        in_isr         <= 1'b1;
                        intr_ack       <= 1'b1;
                        state          <= INT_VEC;
                    end else begin
                        if (pc_write_en) pc <= pc_plus1;
                        if (flush) begin
                            if_id_instr <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                        end else if (if_id_write_en) begin
                            if_id_instr    <= imem.imem_rdata;
                            if_id_pc_plus1 <= pc_plus1;
                            if_id_valid    <= 1'b1;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
